// File: rtl/rx_frame_loader.sv
// rx_frame_loader
//   Assembles one grayscale frame received byte-by-byte from the serial receiver
//   into the image RAM ahead of the Sobel pipeline. A frame is a SYNC byte,
//   NPIX pixel bytes and one checksum byte (mod-256 sum of the pixels).
//   A good frame produces a one-cycle frame_ok pulse; a checksum mismatch or an
//   inter-byte stall longer than TIMEOUT cycles produces a one-cycle frame_erro.
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset_n     in   1       asynchronous active-low reset
//   rx_pronto   in   1       rx_dado valid this cycle (one-cycle strobe)
//   rx_dado     in   8       received byte
//   ocupado     in   1       Sobel stage busy; new frames refused while high
//   we_mem      out  1       image RAM write enable
//   addr_mem    out  ADDR_W  image RAM write address
//   dado_mem    out  8       image RAM write data
//   frame_ok    out  1       pulse: frame stored, checksum matched
//   frame_erro  out  1       pulse: frame rejected
//   erro_cod    out  2       00 none, 01 checksum, 10 timeout (held until next sync)
//   db_estado   out  4       current state code (debug)
module rx_frame_loader #(
  parameter int          NPIX    = 4096,
  parameter int          ADDR_W  = 12,
  parameter logic [7:0]  SYNC    = 8'hAA,
  parameter int          TIMEOUT = 1000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_pronto,
  input  logic [7:0]        rx_dado,
  input  logic              ocupado,
  output logic              we_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [7:0]        dado_mem,
  output logic              frame_ok,
  output logic              frame_erro,
  output logic [1:0]        erro_cod,
  output logic [3:0]        db_estado
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] COD_NONE = 2'b00;
  localparam logic [1:0] COD_CKS  = 2'b01;
  localparam logic [1:0] COD_TMO  = 2'b10;

  // Encodings are the debug codes seen on db_estado.
  typedef enum logic [3:0] {
    OCIOSO   = 4'h0,
    PIXEL    = 4'h3,
    CHECK    = 4'h7,
    VALIDA   = 4'h9,
    FIM_OK   = 4'hF,
    FIM_ERRO = 4'hE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          cks_q, cks_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dado_q, dado_d;
  logic                ok_q, ok_d;
  logic                erro_q, erro_d;
  logic [1:0]          cod_q, cod_d;

  logic                tmo_expired;

  // Expiry only counts when no byte arrives in the same cycle; a byte wins.
  assign tmo_expired = !rx_pronto && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cks_d   = cks_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    dado_d  = dado_q;
    ok_d    = 1'b0;
    erro_d  = 1'b0;
    cod_d   = cod_q;

    case (state_q)
      OCIOSO: begin
        // ocupado is only looked at here; it never aborts a frame in flight.
        if (rx_pronto && (rx_dado == SYNC) && !ocupado) begin
          state_d = PIXEL;
          cnt_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
          cod_d   = COD_NONE;
        end
      end

      PIXEL: begin
        if (rx_pronto) begin
          // Any value, including SYNC, is pixel data here.
          we_d   = 1'b1;
          addr_d = cnt_q;
          dado_d = rx_dado;
          sum_d  = sum_q + rx_dado;
          cnt_d  = cnt_q + 1'b1;
          tmo_d  = '0;
          if (cnt_q == LAST_PIX) begin
            state_d = CHECK;
          end
        end else if (tmo_expired) begin
          cod_d   = COD_TMO;
          erro_d  = 1'b1;
          state_d = FIM_ERRO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CHECK: begin
        if (rx_pronto) begin
          cks_d   = rx_dado;
          tmo_d   = '0;
          state_d = VALIDA;
        end else if (tmo_expired) begin
          cod_d   = COD_TMO;
          erro_d  = 1'b1;
          state_d = FIM_ERRO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      VALIDA: begin
        // Pulses are registered on entry so they coincide with FIM_OK/FIM_ERRO.
        if (cks_q == sum_q) begin
          ok_d    = 1'b1;
          state_d = FIM_OK;
        end else begin
          cod_d   = COD_CKS;
          erro_d  = 1'b1;
          state_d = FIM_ERRO;
        end
      end

      FIM_OK:   state_d = OCIOSO;
      FIM_ERRO: state_d = OCIOSO;

      default:  state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      sum_q   <= '0;
      cks_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dado_q  <= '0;
      ok_q    <= 1'b0;
      erro_q  <= 1'b0;
      cod_q   <= COD_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cks_q   <= cks_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dado_q  <= dado_d;
      ok_q    <= ok_d;
      erro_q  <= erro_d;
      cod_q   <= cod_d;
    end
  end

  assign we_mem     = we_q;
  assign addr_mem   = addr_q;
  assign dado_mem   = dado_q;
  assign frame_ok   = ok_q;
  assign frame_erro = erro_q;
  assign erro_cod   = cod_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_rx_frame_loader.sv
module tb_rx_frame_loader;

  logic       clock;
  logic       reset_n;
  logic       rx_pronto;
  logic [7:0] rx_dado;
  logic       ocupado;
  logic       we_mem;
  logic [1:0] addr_mem;
  logic [7:0] dado_mem;
  logic       frame_ok;
  logic       frame_erro;
  logic [1:0] erro_cod;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int ok_cnt = 0;
  int er_cnt = 0;

  rx_frame_loader #(
    .NPIX    (4),
    .ADDR_W  (2),
    .SYNC    (8'hAA),
    .TIMEOUT (50)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_pronto  (rx_pronto),
    .rx_dado    (rx_dado),
    .ocupado    (ocupado),
    .we_mem     (we_mem),
    .addr_mem   (addr_mem),
    .dado_mem   (dado_mem),
    .frame_ok   (frame_ok),
    .frame_erro (frame_erro),
    .erro_cod   (erro_cod),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counts of writes and pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (we_mem === 1'b1)     wr_cnt++;
    if (frame_ok === 1'b1)   ok_cnt++;
    if (frame_erro === 1'b1) er_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one byte for exactly one clock; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_pronto = 1'b1;
    rx_dado   = b;
    @(posedge clock);
    #1;
    rx_pronto = 1'b0;
    rx_dado   = 8'h00;
  endtask

  // Full frame with per-byte write checks and end-of-frame result checks.
  task automatic frame(input string tag, input logic [31:0] px, input logic [7:0] cks,
                       input bit exp_ok);
    int w0, o0, e0;
    logic [7:0] p;
    w0 = wr_cnt; o0 = ok_cnt; e0 = er_cnt;
    send(8'hAA);
    chk({tag, ".sync_nowrite"}, 32'(we_mem), 0);
    chk({tag, ".st_pixel"}, 32'(db_estado), 32'h3);
    for (int i = 0; i < 4; i++) begin
      p = px[31-8*i -: 8];
      send(p);
      chk({tag, ".we"}, 32'(we_mem), 1);
      chk({tag, ".addr"}, 32'(addr_mem), 32'(i));
      chk({tag, ".dado"}, 32'(dado_mem), 32'(p));
    end
    chk({tag, ".st_check"}, 32'(db_estado), 32'h7);
    send(cks);
    chk({tag, ".cks_nowrite"}, 32'(we_mem), 0);
    chk({tag, ".st_valida"}, 32'(db_estado), 32'h9);
    idle(1);
    if (exp_ok) begin
      chk({tag, ".frame_ok"}, 32'(frame_ok), 1);
      chk({tag, ".st_fim_ok"}, 32'(db_estado), 32'hF);
    end else begin
      chk({tag, ".frame_erro"}, 32'(frame_erro), 1);
      chk({tag, ".st_fim_erro"}, 32'(db_estado), 32'hE);
    end
    idle(1);
    chk({tag, ".st_idle"}, 32'(db_estado), 32'h0);
    chk({tag, ".ok_low"}, 32'(frame_ok), 0);
    chk({tag, ".erro_low"}, 32'(frame_erro), 0);
    idle(2);
    chk({tag, ".n_writes"}, 32'(wr_cnt - w0), 4);
    chk({tag, ".n_ok"}, 32'(ok_cnt - o0), exp_ok ? 32'd1 : 32'd0);
    chk({tag, ".n_erro"}, 32'(er_cnt - e0), exp_ok ? 32'd0 : 32'd1);
    chk({tag, ".cod"}, 32'(erro_cod), exp_ok ? 32'd0 : 32'd1);
  endtask

  initial begin
    int w0, o0, e0;
    reset_n   = 1'b0;
    rx_pronto = 1'b0;
    rx_dado   = 8'h00;
    ocupado   = 1'b0;

    // Reset state
    idle(2);
    chk("rst.we", 32'(we_mem), 0);
    chk("rst.addr", 32'(addr_mem), 0);
    chk("rst.dado", 32'(dado_mem), 0);
    chk("rst.ok", 32'(frame_ok), 0);
    chk("rst.erro", 32'(frame_erro), 0);
    chk("rst.cod", 32'(erro_cod), 0);
    chk("rst.st", 32'(db_estado), 0);
    reset_n = 1'b1;
    idle(2);

    // 1: good frame
    frame("t1", 32'h10203040, 8'hA0, 1'b1);

    // 2: bad checksum
    frame("t2", 32'h10203040, 8'hA1, 1'b0);

    // 3: junk before sync, then SYNC-valued pixels
    send(8'h55);
    chk("t3.junk_nowrite", 32'(we_mem), 0);
    chk("t3.junk_idle", 32'(db_estado), 0);
    frame("t3a", 32'h01020304, 8'h0A, 1'b1);
    frame("t3b", 32'hAAAAAAAA, 8'hA8, 1'b1);

    // 4: timeout 50 cycles after the last accepted byte
    send(8'hAA);
    send(8'h11);
    send(8'h22);
    idle(49);
    chk("t4.no_erro_yet", 32'(frame_erro), 0);
    chk("t4.still_pixel", 32'(db_estado), 32'h3);
    idle(1);
    chk("t4.erro_pulse", 32'(frame_erro), 1);
    chk("t4.cod_tmo", 32'(erro_cod), 2);
    chk("t4.st_fim_erro", 32'(db_estado), 32'hE);
    idle(1);
    chk("t4.st_idle", 32'(db_estado), 0);
    chk("t4.erro_low", 32'(frame_erro), 0);
    idle(3);
    chk("t4.cod_held", 32'(erro_cod), 2);
    // byte arriving on the expiry cycle keeps the frame alive
    o0 = ok_cnt; e0 = er_cnt;
    send(8'hAA);
    chk("t4b.cod_cleared", 32'(erro_cod), 0);
    send(8'h11);
    send(8'h22);
    idle(49);
    send(8'h33);
    chk("t4b.late_we", 32'(we_mem), 1);
    chk("t4b.late_addr", 32'(addr_mem), 2);
    chk("t4b.late_dado", 32'(dado_mem), 32'h33);
    chk("t4b.alive", 32'(db_estado), 32'h3);
    send(8'h44);
    send(8'hAA);
    idle(4);
    chk("t4b.n_ok", 32'(ok_cnt - o0), 1);
    chk("t4b.n_erro", 32'(er_cnt - e0), 0);
    chk("t4b.cod", 32'(erro_cod), 0);

    // 5: ocupado refuses the frame entirely
    ocupado = 1'b1;
    w0 = wr_cnt; o0 = ok_cnt; e0 = er_cnt;
    send(8'hAA);
    chk("t5.refused", 32'(db_estado), 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
    idle(4);
    chk("t5.n_writes", 32'(wr_cnt - w0), 0);
    chk("t5.n_ok", 32'(ok_cnt - o0), 0);
    chk("t5.n_erro", 32'(er_cnt - e0), 0);
    chk("t5.st", 32'(db_estado), 0);
    ocupado = 1'b0;
    frame("t5b", 32'h01020304, 8'h0A, 1'b1);

    // 6: asynchronous reset mid-frame
    send(8'hAA);
    send(8'h01);
    send(8'h02);
    chk("t6.pre_we", 32'(we_mem), 1);
    w0 = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk("t6.async_we", 32'(we_mem), 0);
    chk("t6.async_addr", 32'(addr_mem), 0);
    chk("t6.async_dado", 32'(dado_mem), 0);
    chk("t6.async_st", 32'(db_estado), 0);
    chk("t6.async_cod", 32'(erro_cod), 0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    chk("t6.no_write_in_rst", 32'(wr_cnt - w0), 0);
    frame("t6b", 32'h05060708, 8'h1A, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
